// File: rtl/pkt_rx_resp.sv
// Packet responder: buffers payload, checks trailing XOR checksum, forwards good packets
// store-and-forward and reports one status pulse per packet. Optional PKT_RX_STATS_EN adds good/bad counters.
`timescale 1ns/1ps
module pkt_rx_resp #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          sts_valid,
    output logic          sts_ok,
    output logic [LW-1:0] sts_len
`ifdef PKT_RX_STATS_EN
    ,
    output logic [15:0]   stat_good,
    output logic [15:0]   stat_bad
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_DROP  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_nxt;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          sts_valid_q, sts_valid_d;
    logic          sts_ok_q, sts_ok_d;
    logic [LW-1:0] sts_len_q, sts_len_d;
    logic          wr_en;
    logic          in_fire;
    logic          out_fire;
    logic [DW-1:0] mem_q [DEPTH];

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign rd_nxt   = rd_ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        sts_valid_d = 1'b0;
        sts_ok_d    = sts_ok_q;
        sts_len_d   = sts_len_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    if (in_last) begin
                        sts_valid_d = 1'b1;
                        sts_ok_d    = (in_data == '0);
                        sts_len_d   = '0;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        acc_d    = in_data;
                        len_d    = LW'(1);
                        state_d  = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (in_fire) begin
                    if (in_last) begin
                        sts_valid_d = 1'b1;
                        sts_ok_d    = (in_data == acc_q);
                        sts_len_d   = len_q;
                        if (in_data == acc_q) begin
                            // Preload the head word so the first beat appears the next cycle.
                            state_d     = S_SEND;
                            out_valid_d = 1'b1;
                            out_data_d  = mem_q[rd_ptr_q];
                            out_last_d  = (len_q == LW'(1));
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end else if (len_q == DEPTH_L) begin
                        state_d = S_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        acc_d    = acc_q ^ in_data;
                        len_d    = len_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (in_fire && in_last) begin
                    sts_valid_d = 1'b1;
                    sts_ok_d    = 1'b0;
                    sts_len_d   = DEPTH_L;
                    state_d     = S_FLUSH;
                end
            end
            S_SEND: begin
                // len_q counts words still to be popped while sending.
                if (out_fire) begin
                    if (len_q == LW'(1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        acc_d       = '0;
                        len_d       = '0;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        state_d     = S_IDLE;
                    end else begin
                        rd_ptr_d   = rd_nxt;
                        len_d      = len_q - 1'b1;
                        out_data_d = mem_q[rd_nxt];
                        out_last_d = (len_q == LW'(2));
                    end
                end
            end
            S_FLUSH: begin
                acc_d    = '0;
                len_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                acc_d    = '0;
                len_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_RECV) || (state_d == S_DROP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            sts_valid_q <= 1'b0;
            sts_ok_q    <= 1'b0;
            sts_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            sts_valid_q <= sts_valid_d;
            sts_ok_q    <= sts_ok_d;
            sts_len_q   <= sts_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef PKT_RX_STATS_EN
    logic [15:0] stat_good_q, stat_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
        end else if (sts_valid_d) begin
            if (sts_ok_d && (stat_good_q != 16'hFFFF)) begin
                stat_good_q <= stat_good_q + 1'b1;
            end else if (!sts_ok_d && (stat_bad_q != 16'hFFFF)) begin
                stat_bad_q <= stat_bad_q + 1'b1;
            end
        end
    end

    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign sts_valid = sts_valid_q;
    assign sts_ok    = sts_ok_q;
    assign sts_len   = sts_len_q;

endmodule
